// File: rtl/translate_pkg.sv
// Shared types for the pixel-translate frame sequencer.
// Beat tags carry the translated coordinate alongside each read.
package translate_pkg;

    localparam int COORD_W  = 10;
    localparam int DCOORD_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [DCOORD_W-1:0] x;
        logic [DCOORD_W-1:0] y;
        logic                in_bounds;
        logic                sof;
        logic                eol;
    } tag_t;

endpackage

// File: rtl/translate_skid_buf.sv
// Two-entry valid/ready beat buffer with occupancy output.
// The head entry never moves while it waits, so a stalled beat holds stable.
module translate_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wp_q;
    logic             rp_q;
    logic [1:0]       cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= push_data_i;
                wp_q        <= ~wp_q;
            end
            if (pop_i) begin
                rp_q <= ~rp_q;
            end
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign valid_o = (cnt_q != 2'd0);
    assign head_o  = mem_q[rp_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/translate_scan_ctrl.sv
// Raster-scan read sequencer that tags each pixel with its shifted
// destination coordinate and streams it out through a 2-entry buffer.
module translate_scan_ctrl
    import translate_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [COORD_W-1:0]    shift_x_cfg,
    input  logic [COORD_W-1:0]    shift_y_cfg,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pixel,
    output logic [DCOORD_W-1:0]   out_x,
    output logic [DCOORD_W-1:0]   out_y,
    output logic                  out_in_bounds,
    output logic                  out_sof,
    output logic                  out_eol
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pixel;
        tag_t                  tag;
    } beat_t;

    state_e                state_q, state_d;
    logic [COORD_W-1:0]    x_q, x_d;
    logic [COORD_W-1:0]    y_q, y_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [COORD_W-1:0]    sx_q, sx_d;
    logic [COORD_W-1:0]    sy_q, sy_d;
    logic                  inflight_q;
    tag_t                  tag_q, tag_d;

    beat_t      push_beat;
    beat_t      head_beat;
    logic [1:0] occ;
    logic       pop;
    logic       can_issue;
    logic       last_rd;

    assign pop = out_valid && out_ready;

    // Reserve a slot for every read in flight so a stall can never overflow.
    assign can_issue = (3'(occ) + 3'(inflight_q) - 3'(pop)) < 3'd2;
    assign rd_en     = (state_q == RUN) && can_issue;
    assign last_rd   = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        tag_d           = '0;
        tag_d.x         = DCOORD_W'(x_q) + DCOORD_W'(sx_q);
        tag_d.y         = DCOORD_W'(y_q) + DCOORD_W'(sy_q);
        tag_d.in_bounds = (tag_d.x < DCOORD_W'(IMG_WIDTH)) &&
                          (tag_d.y < DCOORD_W'(IMG_HEIGHT));
        tag_d.sof       = (x_q == '0) && (y_q == '0);
        tag_d.eol       = (x_q == X_LAST);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    sx_d    = shift_x_cfg;
                    sy_d    = shift_y_cfg;
                end
            end
            RUN: begin
                if (rd_en) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = y_q + COORD_W'(1);
                    end else begin
                        x_d = x_q + COORD_W'(1);
                    end
                    if (last_rd) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as soon as the final beat is being accepted.
                if ((occ == 2'(pop)) && !inflight_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            inflight_q <= rd_en;
            if (rd_en) begin
                tag_q <= tag_d;
            end
        end
    end

    assign push_beat.pixel = rd_data;
    assign push_beat.tag   = tag_q;

    translate_skid_buf #(
        .WIDTH($bits(beat_t))
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_data_i(push_beat),
        .pop_i      (pop),
        .valid_o    (out_valid),
        .head_o     (head_beat),
        .count_o    (occ)
    );

    assign out_pixel     = head_beat.pixel;
    assign out_x         = head_beat.tag.x;
    assign out_y         = head_beat.tag.y;
    assign out_in_bounds = head_beat.tag.in_bounds;
    assign out_sof       = head_beat.tag.sof;
    assign out_eol       = head_beat.tag.eol;

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign rd_addr = addr_q;

endmodule

// File: tb/tb_translate_scan_ctrl.sv
// Directed bench for translate_scan_ctrl on a 4x3 frame.
// Memory model returns rd_addr as pixel data one cycle after rd_en.
module tb_translate_scan_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [9:0]    shift_x_cfg;
    logic [9:0]    shift_y_cfg;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pixel;
    logic [10:0]   out_x;
    logic [10:0]   out_y;
    logic          out_in_bounds;
    logic          out_sof;
    logic          out_eol;

    int nvec = 0;
    int nerr = 0;

    int nbeats, nib, nrd, first_rd, last_rd, first_beat, last_beat, done_cyc;

    translate_scan_ctrl #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .shift_x_cfg  (shift_x_cfg),
        .shift_y_cfg  (shift_y_cfg),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pixel    (out_pixel),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_in_bounds(out_in_bounds),
        .out_sof      (out_sof),
        .out_eol      (out_eol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= DW'(rd_addr);
    end

    // Runs one frame from start; cycle 1 is the cycle after start is sampled.
    task automatic run_frame(input int sx, input int sy, input int duty,
                             input int poke_cyc, input int poke_sx);
        int          outst;
        bit          stalled;
        bit          pop;
        logic [32:0] cur, held, expv;
        logic [10:0] ex, ey;
        int          px, py;
        outst = 0; stalled = 0; held = '0;
        nbeats = 0; nib = 0; nrd = 0;
        first_rd = -1; last_rd = -1; first_beat = -1; last_beat = -1;
        done_cyc = -1;
        @(negedge clk);
        start = 1'b1;
        shift_x_cfg = 10'(sx);
        shift_y_cfg = 10'(sy);
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 400 && done_cyc < 0; cyc++) begin
            if (cyc == poke_cyc) begin
                start = 1'b1;
                shift_x_cfg = 10'(poke_sx);
            end else begin
                start = 1'b0;
            end
            out_ready = ($urandom_range(0, 99) < duty);
            #1;
            cur = {out_pixel, out_x, out_y, out_in_bounds, out_sof, out_eol};
            pop = out_valid && out_ready;
            if (stalled) begin
                nvec++;
                if (!out_valid || cur !== held) begin
                    nerr++;
                    $display("FAIL hold cyc %0d: got v=%b %h, need v=1 %h",
                             cyc, out_valid, cur, held);
                end
            end
            if (rd_en) begin
                nrd++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                nvec++;
                if (outst - int'(pop) >= 2) begin
                    nerr++;
                    $display("FAIL credit cyc %0d: got outstanding %0d pop %0d, need < 2",
                             cyc, outst, pop);
                end
            end
            if (pop) begin
                px = nbeats % W;
                py = nbeats / W;
                ex = 11'(px + sx);
                ey = 11'(py + sy);
                expv = {8'(nbeats), ex, ey, (ex < W) && (ey < H),
                        nbeats == 0, px == W - 1};
                nvec++;
                if (nbeats >= W * H || cur !== expv) begin
                    nerr++;
                    $display("FAIL beat %0d: got %h, need %h", nbeats, cur, expv);
                end
                if (out_in_bounds) nib++;
                if (first_beat < 0) first_beat = cyc;
                last_beat = cyc;
                nbeats++;
            end
            if (done) done_cyc = cyc;
            stalled = out_valid && !out_ready;
            held = cur;
            outst = outst + int'(rd_en) - int'(pop);
            @(negedge clk);
        end
        start = 1'b0;
        nvec++;
        if (done_cyc < 0) begin
            nerr++;
            $display("FAIL timeout: got no done, need done within 400 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        shift_x_cfg = '0;
        shift_y_cfg = '0;
        repeat (2) @(negedge clk);
        nvec++;
        if ({busy, done, rd_en, out_valid} !== 4'b0) begin
            nerr++;
            $display("FAIL reset_ctl: got %b, need 0000", {busy, done, rd_en, out_valid});
        end
        nvec++;
        if ({rd_addr, out_pixel, out_x, out_y, out_in_bounds, out_sof, out_eol} !== '0) begin
            nerr++;
            $display("FAIL reset_data: got addr %0d pix %0d x %0d y %0d, need 0",
                     rd_addr, out_pixel, out_x, out_y);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_frame(1, 1, 100, 0, 0);
        nvec++;
        if (nbeats != 12) begin
            nerr++; $display("FAIL basic_beats: got %0d, need 12", nbeats);
        end
        nvec++;
        if (nib != 6) begin
            nerr++; $display("FAIL basic_inbounds: got %0d, need 6", nib);
        end
        nvec++;
        if (first_rd != 1 || nrd != 12 || last_rd != 12) begin
            nerr++;
            $display("FAIL basic_rd: got first %0d last %0d count %0d, need 1 12 12",
                     first_rd, last_rd, nrd);
        end
        nvec++;
        if (first_beat != 3 || last_beat != 14) begin
            nerr++;
            $display("FAIL basic_latency: got first %0d last %0d, need 3 14",
                     first_beat, last_beat);
        end
        nvec++;
        if (done_cyc != 15) begin
            nerr++; $display("FAIL basic_done: got cycle %0d, need 15", done_cyc);
        end
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL basic_idle: got done %b busy %b, need 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        run_frame(1, 1, 30, 0, 0);
        nvec++;
        if (nbeats != 12 || nib != 6) begin
            nerr++;
            $display("FAIL stall_beats: got %0d/%0d, need 12/6", nbeats, nib);
        end
        nvec++;
        if (done_cyc != last_beat + 1) begin
            nerr++;
            $display("FAIL stall_done: got cycle %0d, need %0d", done_cyc, last_beat + 1);
        end
    endtask

    task automatic test_bounds();
        run_frame(0, 0, 100, 0, 0);
        nvec++;
        if (nbeats != 12 || nib != 12) begin
            nerr++;
            $display("FAIL bounds_00: got %0d/%0d, need 12/12", nbeats, nib);
        end
        run_frame(4, 0, 100, 0, 0);
        nvec++;
        if (nbeats != 12 || nib != 0) begin
            nerr++;
            $display("FAIL bounds_40: got %0d/%0d, need 12/0", nbeats, nib);
        end
        run_frame(0, 3, 60, 0, 0);
        nvec++;
        if (nbeats != 12 || nib != 0) begin
            nerr++;
            $display("FAIL bounds_03: got %0d/%0d, need 12/0", nbeats, nib);
        end
    endtask

    task automatic test_restart_ignored();
        int extra;
        run_frame(1, 1, 100, 5, 2);
        nvec++;
        if (nbeats != 12 || nib != 6) begin
            nerr++;
            $display("FAIL restart_frame: got %0d/%0d, need 12/6", nbeats, nib);
        end
        extra = 0;
        repeat (6) begin
            if (busy || rd_en) extra++;
            @(negedge clk);
        end
        nvec++;
        if (extra != 0) begin
            nerr++;
            $display("FAIL restart_second: got %0d active cycles, need 0", extra);
        end
        run_frame(2, 0, 100, 0, 0);
        nvec++;
        if (nbeats != 12 || nib != 6) begin
            nerr++;
            $display("FAIL restart_new: got %0d/%0d, need 12/6", nbeats, nib);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b1;
        shift_x_cfg = 10'd1;
        shift_y_cfg = 10'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        nvec++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL midrst_pending: got valid %b busy %b, need 1 1", out_valid, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nvec++;
        if ({busy, done, rd_en, out_valid, rd_addr, out_pixel, out_x, out_y,
             out_in_bounds, out_sof, out_eol} !== '0) begin
            nerr++;
            $display("FAIL midrst_zero: got busy %b valid %b addr %0d pix %0d, need 0",
                     busy, out_valid, rd_addr, out_pixel);
        end
        seen = 0;
        repeat (5) begin
            if (done || busy || out_valid) seen++;
            @(negedge clk);
        end
        nvec++;
        if (seen != 0) begin
            nerr++; $display("FAIL midrst_quiet: got %0d active cycles, need 0", seen);
        end
        run_frame(1, 1, 100, 0, 0);
        nvec++;
        if (nbeats != 12 || done_cyc != 15) begin
            nerr++;
            $display("FAIL midrst_frame: got %0d beats done %0d, need 12 15",
                     nbeats, done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_bounds();
        test_restart_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
